// File: rtl/operand_forward_unit.sv
// operand_forward_unit
//
// Resolves read-after-write hazards for the two source operands of the
// instruction leaving ID and registers them at the ID->EX boundary.
//
// Operand sources, highest priority first:
//   rsN == x0          -> zero
//   EX-stage producer  -> "pending" flag; value is picked up next cycle from
//                         the MA result bus, where the producer will then be
//   MA-stage producer  -> i_ma_result
//   WB-stage write     -> i_wb_data (regfile write is synchronous, so the
//                         async read port still shows the stale value)
//   otherwise          -> regfile async read data
//
// An EX-stage load feeding the ID instruction cannot be forwarded in time.
// This is flagged on o_load_use_hazard, which is combinational, and a bubble
// is inserted into EX.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_stall                 global stall, all state holds
//   i_flush                 kill the instruction entering EX
//   i_id_*                  ID valid, source indices
//   i_rf_rs1/2_data         async regfile read data for the ID indices
//   i_ex_*                  EX-stage producer (valid, reg_write, is_load, rd)
//   i_ma_*                  MA-stage producer (valid, reg_write, rd, result)
//   i_wb_*                  WB write port (reg_write, rd, data)
//   o_ex_valid              valid instruction in EX
//   o_ex_rs1/2_data         resolved EX operands
//   o_load_use_hazard       ID must hold this cycle
//
// Optional build macro FWD_PERF_COUNTERS_EN adds two saturating 32-bit
// counters: o_fwd_event_count (accepted ID instructions that used a bypass)
// and o_load_use_count (unstalled load-use hazard cycles).

module operand_forward_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic                  i_flush,

    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic [XLEN-1:0]       i_rf_rs1_data,
    input  logic [XLEN-1:0]       i_rf_rs2_data,

    input  logic                  i_ex_valid,
    input  logic                  i_ex_reg_write,
    input  logic                  i_ex_is_load,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,

    input  logic                  i_ma_valid,
    input  logic                  i_ma_reg_write,
    input  logic [REG_ADDR_W-1:0] i_ma_rd,
    input  logic [XLEN-1:0]       i_ma_result,

    input  logic                  i_wb_reg_write,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic [XLEN-1:0]       i_wb_data,

    output logic                  o_ex_valid,
    output logic [XLEN-1:0]       o_ex_rs1_data,
    output logic [XLEN-1:0]       o_ex_rs2_data,
    output logic                  o_load_use_hazard
`ifdef FWD_PERF_COUNTERS_EN
    ,
    output logic [31:0]           o_fwd_event_count,
    output logic [31:0]           o_load_use_count
`endif
);

    // ------------------------------------------------------------------
    // Producer match detection
    // ------------------------------------------------------------------
    logic rs1_nz, rs2_nz;
    logic ex_hit1, ex_hit2;
    logic ma_hit1, ma_hit2;
    logic wb_hit1, wb_hit2;
    logic ex_writes, ma_writes;

    assign rs1_nz    = (i_id_rs1 != '0);
    assign rs2_nz    = (i_id_rs2 != '0);

    assign ex_writes = i_ex_valid & i_ex_reg_write;
    assign ma_writes = i_ma_valid & i_ma_reg_write;

    // Comparing against a nonzero rs also rules out rd == x0.
    assign ex_hit1 = ex_writes & (i_ex_rd == i_id_rs1) & rs1_nz;
    assign ex_hit2 = ex_writes & (i_ex_rd == i_id_rs2) & rs2_nz;
    assign ma_hit1 = ma_writes & (i_ma_rd == i_id_rs1) & rs1_nz;
    assign ma_hit2 = ma_writes & (i_ma_rd == i_id_rs2) & rs2_nz;
    assign wb_hit1 = i_wb_reg_write & (i_wb_rd == i_id_rs1) & rs1_nz;
    assign wb_hit2 = i_wb_reg_write & (i_wb_rd == i_id_rs2) & rs2_nz;

    // ------------------------------------------------------------------
    // Load-use hazard (independent of stall)
    // ------------------------------------------------------------------
    logic load_use;

    assign load_use          = i_id_valid & i_ex_is_load & (ex_hit1 | ex_hit2);
    assign o_load_use_hazard = load_use;

    // ------------------------------------------------------------------
    // ID-cycle operand selection
    // ------------------------------------------------------------------
    logic            sel_pend1, sel_pend2;
    logic [XLEN-1:0] sel_data1, sel_data2;

    always_comb begin
        sel_pend1 = 1'b0;
        sel_data1 = i_rf_rs1_data;
        if (!rs1_nz) begin
            sel_data1 = '0;
        end else if (ex_hit1) begin
            // Youngest producer wins; value arrives on the MA bus next cycle.
            sel_pend1 = 1'b1;
            sel_data1 = '0;
        end else if (ma_hit1) begin
            sel_data1 = i_ma_result;
        end else if (wb_hit1) begin
            sel_data1 = i_wb_data;
        end
    end

    always_comb begin
        sel_pend2 = 1'b0;
        sel_data2 = i_rf_rs2_data;
        if (!rs2_nz) begin
            sel_data2 = '0;
        end else if (ex_hit2) begin
            sel_pend2 = 1'b1;
            sel_data2 = '0;
        end else if (ma_hit2) begin
            sel_data2 = i_ma_result;
        end else if (wb_hit2) begin
            sel_data2 = i_wb_data;
        end
    end

    // ------------------------------------------------------------------
    // ID->EX pipeline register
    // ------------------------------------------------------------------
    logic            ex_valid_q, ex_valid_d;
    logic            pend1_q, pend1_d;
    logic            pend2_q, pend2_d;
    logic [XLEN-1:0] data1_q, data1_d;
    logic [XLEN-1:0] data2_q, data2_d;

    always_comb begin
        ex_valid_d = ex_valid_q;
        pend1_d    = pend1_q;
        pend2_d    = pend2_q;
        data1_d    = data1_q;
        data2_d    = data2_q;
        if (i_stall) begin
            // Hold: the MA producer is frozen too, so pending forwards stay valid.
        end else if (i_flush || load_use) begin
            // Bubble; captured data is irrelevant and simply held.
            ex_valid_d = 1'b0;
            pend1_d    = 1'b0;
            pend2_d    = 1'b0;
        end else begin
            ex_valid_d = i_id_valid;
            pend1_d    = sel_pend1;
            pend2_d    = sel_pend2;
            data1_d    = sel_data1;
            data2_d    = sel_data2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_valid_q <= 1'b0;
            pend1_q    <= 1'b0;
            pend2_q    <= 1'b0;
            data1_q    <= '0;
            data2_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            pend1_q    <= pend1_d;
            pend2_q    <= pend2_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
        end
    end

    // ------------------------------------------------------------------
    // EX-cycle outputs: the EX producer seen last cycle is now in MA.
    // ------------------------------------------------------------------
    assign o_ex_valid    = ex_valid_q;
    assign o_ex_rs1_data = pend1_q ? i_ma_result : data1_q;
    assign o_ex_rs2_data = pend2_q ? i_ma_result : data2_q;

`ifdef FWD_PERF_COUNTERS_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic        fwd_event;
    logic        lu_event;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic [31:0] lu_cnt_q, lu_cnt_d;

    assign fwd_event = ~i_stall & i_id_valid & ~load_use & ~i_flush &
                       (ex_hit1 | ma_hit1 | wb_hit1 | ex_hit2 | ma_hit2 | wb_hit2);
    assign lu_event  = load_use & ~i_stall;

    always_comb begin
        fwd_cnt_d = fwd_cnt_q;
        lu_cnt_d  = lu_cnt_q;
        if (fwd_event && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
        if (lu_event && (lu_cnt_q != 32'hFFFF_FFFF)) begin
            lu_cnt_d = lu_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fwd_cnt_q <= '0;
            lu_cnt_q  <= '0;
        end else begin
            fwd_cnt_q <= fwd_cnt_d;
            lu_cnt_q  <= lu_cnt_d;
        end
    end

    assign o_fwd_event_count = fwd_cnt_q;
    assign o_load_use_count  = lu_cnt_q;
`endif

endmodule

// File: tb/tb_operand_forward_unit.sv
module tb_operand_forward_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        ex_valid_in, ex_reg_write, ex_is_load;
    logic [4:0]  ex_rd;
    logic        ma_valid, ma_reg_write;
    logic [4:0]  ma_rd;
    logic [31:0] ma_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_rs1_data, ex_rs2_data;
    logic        load_use_hazard;
`ifdef FWD_PERF_COUNTERS_EN
    logic [31:0] fwd_event_count, load_use_count;
`endif

    int checks = 0;
    int errors = 0;

    operand_forward_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_stall           (stall),
        .i_flush           (flush),
        .i_id_valid        (id_valid),
        .i_id_rs1          (id_rs1),
        .i_id_rs2          (id_rs2),
        .i_rf_rs1_data     (rf_rs1_data),
        .i_rf_rs2_data     (rf_rs2_data),
        .i_ex_valid        (ex_valid_in),
        .i_ex_reg_write    (ex_reg_write),
        .i_ex_is_load      (ex_is_load),
        .i_ex_rd           (ex_rd),
        .i_ma_valid        (ma_valid),
        .i_ma_reg_write    (ma_reg_write),
        .i_ma_rd           (ma_rd),
        .i_ma_result       (ma_result),
        .i_wb_reg_write    (wb_reg_write),
        .i_wb_rd           (wb_rd),
        .i_wb_data         (wb_data),
        .o_ex_valid        (ex_valid),
        .o_ex_rs1_data     (ex_rs1_data),
        .o_ex_rs2_data     (ex_rs2_data),
        .o_load_use_hazard (load_use_hazard)
`ifdef FWD_PERF_COUNTERS_EN
        ,
        .o_fwd_event_count (fwd_event_count),
        .o_load_use_count  (load_use_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        stall = 0; flush = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0;
        rf_rs1_data = 0; rf_rs2_data = 0;
        ex_valid_in = 0; ex_reg_write = 0; ex_is_load = 0; ex_rd = 0;
        ma_valid = 0; ma_reg_write = 0; ma_rd = 0; ma_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    endtask

    // Advance one clock, then settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        idv;
        logic [4:0]  rs1, rs2;
        logic [31:0] rf1, rf2;
        logic        exv, exw, exl;
        logic [4:0]  exrd;
        logic        mav, maw;
        logic [4:0]  mard;
        logic [31:0] mares;
        logic        wbw;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        fl;
        logic [31:0] ma_next;  // MA bus value during the EX cycle
        logic        e_haz, e_valid;
        logic [31:0] e1, e2;
    } vec_t;

    localparam int NV = 15;
    vec_t vt[NV];

    // ---------------- reference model ----------------
    // Producers listed youngest first; the first one writing rs supplies it.
    function automatic void resolve(input logic [4:0] rs, input logic [31:0] rf,
                                    output logic pend, output logic [31:0] d);
        logic        w[3];
        logic [4:0]  rd[3];
        logic [31:0] val[3];
        w[0] = ex_valid_in & ex_reg_write; rd[0] = ex_rd; val[0] = 0;
        w[1] = ma_valid & ma_reg_write;    rd[1] = ma_rd; val[1] = ma_result;
        w[2] = wb_reg_write;               rd[2] = wb_rd; val[2] = wb_data;
        pend = 0;
        d    = rf;
        if (rs == 0) begin
            d = 0;
            return;
        end
        for (int k = 0; k < 3; k++) begin
            if (w[k] && rd[k] == rs) begin
                pend = (k == 0);
                d    = val[k];
                return;
            end
        end
    endfunction

    function automatic logic model_hazard();
        logic ex_w;
        ex_w = ex_valid_in & ex_reg_write & ex_is_load;
        return id_valid & ex_w & (((ex_rd == id_rs1) && id_rs1 != 0) ||
                                  ((ex_rd == id_rs2) && id_rs2 != 0));
    endfunction

    logic        m_valid, m_p1, m_p2;
    logic [31:0] m_d1, m_d2;

    initial begin
        vt[0]  = '{1'b1, 5'd3, 5'd4, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0, 5'd0,
                   1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b1, 32'h11, 32'h22};
        vt[1]  = '{1'b1, 5'd5, 5'd6, 32'h0, 32'h66, 1'b0, 1'b0, 1'b0, 5'd0,
                   1'b1, 1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b1, 32'hDEAD, 32'h66};
        vt[2]  = '{1'b1, 5'd5, 5'd6, 32'h0, 32'h66, 1'b0, 1'b0, 1'b0, 5'd0,
                   1'b1, 1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd5, 32'hBEEF, 1'b0, 32'h0,
                   1'b0, 1'b1, 32'hDEAD, 32'h66};
        vt[3]  = '{1'b1, 5'd1, 5'd7, 32'h5, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0,
                   1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234, 1'b0, 32'h0,
                   1'b0, 1'b1, 32'h5, 32'h1234};
        vt[4]  = '{1'b1, 5'd9, 5'd3, 32'h0, 32'h33, 1'b1, 1'b1, 1'b0, 5'd9,
                   1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'hCAFE,
                   1'b0, 1'b1, 32'hCAFE, 32'h33};
        vt[5]  = '{1'b1, 5'd9, 5'd9, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'd9,
                   1'b1, 1'b1, 5'd9, 32'h1111, 1'b1, 5'd9, 32'h3333, 1'b0, 32'h2222,
                   1'b0, 1'b1, 32'h2222, 32'h2222};
        vt[6]  = '{1'b1, 5'd4, 5'd2, 32'h44, 32'h0, 1'b1, 1'b1, 1'b1, 5'd2,
                   1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,
                   1'b1, 1'b0, 32'h0, 32'h0};
        vt[7]  = '{1'b1, 5'd0, 5'd0, 32'hAA, 32'h99, 1'b1, 1'b1, 1'b1, 5'd0,
                   1'b1, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 1'b0, 32'h77,
                   1'b0, 1'b1, 32'h0, 32'h0};
        vt[8]  = '{1'b1, 5'd3, 5'd0, 32'h31, 32'h99, 1'b1, 1'b1, 1'b1, 5'd0,
                   1'b1, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 32'h77,
                   1'b0, 1'b1, 32'h31, 32'h0};
        vt[9]  = '{1'b1, 5'd8, 5'd8, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 5'd0,
                   1'b1, 1'b1, 5'd8, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b1, 32'h77, 32'h77};
        vt[10] = '{1'b1, 5'd3, 5'd4, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0, 5'd0,
                   1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0,
                   1'b0, 1'b0, 32'h0, 32'h0};
        vt[11] = '{1'b1, 5'd2, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd2,
                   1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0,
                   1'b1, 1'b0, 32'h0, 32'h0};
        vt[12] = '{1'b1, 5'd5, 5'd5, 32'h50, 32'h50, 1'b1, 1'b0, 1'b0, 5'd5,
                   1'b0, 1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'h0, 1'b0, 32'hFFFF,
                   1'b0, 1'b1, 32'h50, 32'h50};
        vt[13] = '{1'b0, 5'd3, 5'd2, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 5'd2,
                   1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 32'h0, 32'h0};
        vt[14] = '{1'b1, 5'd3, 5'd4, 32'h11, 32'h22, 1'b1, 1'b1, 1'b1, 5'd2,
                   1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b1, 32'h11, 32'h22};

        idle();
        rst = 1;
        step();
        step();
        chk("reset_valid", {31'd0, ex_valid}, 32'd0);
        chk("reset_rs1", ex_rs1_data, 32'd0);
        chk("reset_rs2", ex_rs2_data, 32'd0);
        chk("reset_hazard", {31'd0, load_use_hazard}, 32'd0);
        rst = 0;
        step();

        // Table-driven single-instruction vectors
        for (int i = 0; i < NV; i++) begin
            idle();
            id_valid = vt[i].idv; id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2;
            rf_rs1_data = vt[i].rf1; rf_rs2_data = vt[i].rf2;
            ex_valid_in = vt[i].exv; ex_reg_write = vt[i].exw;
            ex_is_load = vt[i].exl; ex_rd = vt[i].exrd;
            ma_valid = vt[i].mav; ma_reg_write = vt[i].maw;
            ma_rd = vt[i].mard; ma_result = vt[i].mares;
            wb_reg_write = vt[i].wbw; wb_rd = vt[i].wbrd; wb_data = vt[i].wbd;
            flush = vt[i].fl;
            #1;
            chk($sformatf("v%0d_hazard", i), {31'd0, load_use_hazard}, {31'd0, vt[i].e_haz});
            step();
            idle();
            ma_result = vt[i].ma_next;
            #1;
            chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, vt[i].e_valid});
            if (vt[i].e_valid) begin
                chk($sformatf("v%0d_rs1", i), ex_rs1_data, vt[i].e1);
                chk($sformatf("v%0d_rs2", i), ex_rs2_data, vt[i].e2);
            end
            step();
        end

        // Pending forward held across a 2-cycle stall; flush during stall ignored
        idle();
        id_valid = 1; id_rs1 = 9; id_rs2 = 4; rf_rs2_data = 32'h22;
        ex_valid_in = 1; ex_reg_write = 1; ex_rd = 9;
        step();
        idle();
        stall = 1; flush = 1; ma_result = 32'hCAFE;
        #1;
        chk("stall0_valid", {31'd0, ex_valid}, 32'd1);
        chk("stall0_rs1", ex_rs1_data, 32'hCAFE);
        step();
        #1;
        chk("stall1_valid", {31'd0, ex_valid}, 32'd1);
        chk("stall1_rs1", ex_rs1_data, 32'hCAFE);
        chk("stall1_rs2", ex_rs2_data, 32'h22);
        step();
        stall = 0; flush = 0;
        #1;
        chk("stall2_valid", {31'd0, ex_valid}, 32'd1);
        chk("stall2_rs1", ex_rs1_data, 32'hCAFE);
        step();
        chk("post_stall_valid", {31'd0, ex_valid}, 32'd0);

        // Reset mid-stall clears valid, pend and data
        idle();
        id_valid = 1; id_rs1 = 9; id_rs2 = 4; rf_rs2_data = 32'h22;
        ex_valid_in = 1; ex_reg_write = 1; ex_rd = 9;
        step();
        idle();
        stall = 1; rst = 1; ma_result = 32'hCAFE;
        step();
        rst = 0; stall = 0;
        #1;
        chk("rst_stall_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_stall_rs1", ex_rs1_data, 32'd0);
        chk("rst_stall_rs2", ex_rs2_data, 32'd0);

        // Randomized run against the reference model
        idle();
        rst = 1;
        step();
        rst = 0;
        m_valid = 0; m_p1 = 0; m_p2 = 0; m_d1 = 0; m_d2 = 0;
        for (int c = 0; c < 600; c++) begin
            logic        haz, p1, p2;
            logic [31:0] d1, d2;
            rst          = ($urandom_range(0, 99) < 3);
            stall        = ($urandom_range(0, 99) < 20);
            flush        = ($urandom_range(0, 99) < 10);
            id_valid     = ($urandom_range(0, 99) < 80);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            rf_rs1_data  = $urandom;
            rf_rs2_data  = $urandom;
            ex_valid_in  = $urandom_range(0, 1) == 1;
            ex_reg_write = $urandom_range(0, 3) != 0;
            ex_is_load   = $urandom_range(0, 1) == 1;
            ex_rd        = 5'($urandom_range(0, 3));
            ma_valid     = $urandom_range(0, 3) != 0;
            ma_reg_write = $urandom_range(0, 3) != 0;
            ma_rd        = 5'($urandom_range(0, 3));
            ma_result    = $urandom;
            wb_reg_write = $urandom_range(0, 1) == 1;
            wb_rd        = 5'($urandom_range(0, 3));
            wb_data      = $urandom;
            #1;
            haz = model_hazard();
            chk("rand_hazard", {31'd0, load_use_hazard}, {31'd0, haz});
            chk("rand_valid", {31'd0, ex_valid}, {31'd0, m_valid});
            if (m_valid) begin
                chk("rand_rs1", ex_rs1_data, m_p1 ? ma_result : m_d1);
                chk("rand_rs2", ex_rs2_data, m_p2 ? ma_result : m_d2);
            end
            resolve(id_rs1, rf_rs1_data, p1, d1);
            resolve(id_rs2, rf_rs2_data, p2, d2);
            if (rst) begin
                m_valid = 0; m_p1 = 0; m_p2 = 0; m_d1 = 0; m_d2 = 0;
            end else if (stall) begin
                // state unchanged
            end else if (flush || haz) begin
                m_valid = 0; m_p1 = 0; m_p2 = 0;
            end else begin
                m_valid = id_valid; m_p1 = p1; m_p2 = p2; m_d1 = d1; m_d2 = d2;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_forward_unit.md
Name: operand_forward_unit

Overview:
- Sits between register-file read (ID) and EX, fed by the two regfile read ports plus MA/WB result buses.
- Resolves RAW hazards by bypassing in-flight results into rs1/rs2 and registers the operands at the ID→EX boundary.
- Resolves EX-stage producers late via a registered "pending" flag.
- Detects load-use hazards and inserts an EX bubble.

Parameters:
- XLEN, 32, operand/result width
- REG_ADDR_W, 5, register index width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_stall  in  1  global pipeline stall; all state holds
- i_flush  in  1  kill instruction entering EX
- i_id_valid  in  1  valid instruction in ID
- i_id_rs1, i_id_rs2  in  REG_ADDR_W  ID source register indices
- i_rf_rs1_data, i_rf_rs2_data  in  XLEN  async regfile read data for the ID indices
- i_ex_valid, i_ex_reg_write, i_ex_is_load  in  1 each  EX-stage producer info
- i_ex_rd  in  REG_ADDR_W  EX-stage destination
- i_ma_valid, i_ma_reg_write  in  1 each  MA-stage producer info
- i_ma_rd  in  REG_ADDR_W  MA-stage destination
- i_ma_result  in  XLEN  MA-stage result, valid in the same cycle
- i_wb_reg_write  in  1  WB write enable
- i_wb_rd  in  REG_ADDR_W  WB destination
- i_wb_data  in  XLEN  WB write data
- o_ex_valid  out  1  valid instruction in EX
- o_ex_rs1_data, o_ex_rs2_data  out  XLEN  resolved EX operands
- o_load_use_hazard  out  1  combinational; ID must hold this cycle

Behaviour:
- Match definitions (ID cycle):
  - A producer P matches rsN when P_valid & P_reg_write & (P_rd == rsN) & (rsN != 0). WB uses i_wb_reg_write only.
- ID-cycle operand select, in priority order:
  - rsN==0 → 0.
  - EX match → set pend_N, data don't-care.
  - MA match → i_ma_result.
  - WB match → i_wb_data. The regfile write is synchronous, so it is not yet visible on the async read.
  - Otherwise i_rf_rsN_data.
- Load-use hazard:
  - o_load_use_hazard = i_id_valid & i_ex_is_load & (EX match on rs1 or rs2).
  - Purely combinational, independent of i_stall.
- Register update at posedge:
  - i_rst → ex_valid=0, pend_1=pend_2=0, data regs=0.
  - else if i_stall → hold everything, including pend flags. The MA producer is also frozen, so the live forward remains valid.
  - else if i_flush or o_load_use_hazard → ex_valid=0, pend flags=0 (bubble); data regs don't-care.
  - else → ex_valid=i_id_valid; capture the selected data and pend flags.
- EX-cycle outputs:
  - o_ex_rsN_data = pend_N ? i_ma_result : captured data. The EX producer has advanced to MA.
  - o_ex_valid = ex_valid.
- Reset values: o_ex_valid=0, o_ex_rs1_data=o_ex_rs2_data=0.
  - o_load_use_hazard follows its inputs and is therefore 0 whenever i_id_valid=0.
- Boundary conditions:
  - rd==0 never forwards.
  - Same register matched by EX and MA: EX wins (youngest producer).
  - rs1==rs2: both operands resolve identically.
  - Flush and hazard in the same cycle: bubble.
  - Flush during stall: stall wins (hold).
  - Reset mid-stall clears all state.

Optional Feature:
- Macro FWD_PERF_COUNTERS_EN.
- When defined, adds two ports:
  - o_fwd_event_count out 32: counts cycles where an ID operand was resolved from EX/MA/WB with !i_stall & i_id_valid & !o_load_use_hazard & !i_flush.
  - o_load_use_count out 32: counts cycles with o_load_use_hazard & !i_stall.
- Both counters are saturating at 0xFFFFFFFF and cleared by i_rst.
- When undefined, the ports and counters are absent and no logic is generated.

Test Plan:
- No hazards: rs1=3, rs2=4, rf data 0x11/0x22, no producer match → next cycle o_ex_valid=1, operands 0x11/0x22.
- MA forward: rs1=5, MA rd=5 result 0xDEAD, rf data 0x0 → o_ex_rs1_data=0xDEAD. Same case with an additional WB rd=5 data 0xBEEF → still 0xDEAD.
- WB bypass: rs2=7, WB rd=7 data 0x1234, rf stale 0x0 → o_ex_rs2_data=0x1234.
- EX pending forward: rs1=9, EX rd=9 non-load → pend set. Next cycle i_ma_result=0xCAFE → o_ex_rs1_data=0xCAFE. Add a 2-cycle stall with MA held → output still 0xCAFE.
- Load-use: EX load rd=2, ID rs2=2 → o_load_use_hazard=1 same cycle, next cycle o_ex_valid=0. Repeat with rs=0 or rd=0 → no hazard and no forward (operand 0).
- Reset/flush: assert i_rst while o_ex_valid=1 and pend set → next cycle o_ex_valid=0, operands 0. i_flush with a valid ID instruction → o_ex_valid=0.
